// File: rtl/in_port_fifo_if.sv
// Handshake bundle between the external device, the input FIFO and the CPU in_port.
// master: device/CPU side; slave: the FIFO itself.
interface in_port_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
);
  logic [WIDTH-1:0] dev_data;
  logic             dev_valid;
  logic             dev_ready;
  logic             cpu_ack;
  logic [WIDTH-1:0] in_port;
  logic             in_avail;
  logic [LW-1:0]    level;
  logic             underflow;
  logic             uf_clr;

  modport master (
    output dev_data, dev_valid, cpu_ack, uf_clr,
    input  dev_ready, in_port, in_avail, level, underflow
  );

  modport slave (
    input  dev_data, dev_valid, cpu_ack, uf_clr,
    output dev_ready, in_port, in_avail, level, underflow
  );
endinterface

// File: rtl/in_port_fifo.sv
// Input-side FIFO feeding the CPU in_port: device valid/ready push, CPU ack pop,
// registered head word that holds its last value when empty, sticky underflow flag.
module in_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          rst,
  in_port_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] in_port_q, in_port_d;
  logic             in_avail_q, in_avail_d;
  logic             underflow_q, underflow_d;
  logic             dev_ready;
  logic             push;
  logic             pop;
  logic             empty;

  assign dev_ready = (level_q != LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign push      = bus.dev_valid && dev_ready;
  assign pop       = bus.cpu_ack && !empty;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.dev_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Head is read from the post-write array so a push into an empty FIFO is visible next cycle.
    in_port_d  = (level_d != '0) ? mem_d[rd_ptr_d] : in_port_q;
    in_avail_d = (level_d != '0);

    if (bus.cpu_ack && empty) begin
      underflow_d = 1'b1;
    end else if (bus.uf_clr) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_port_q   <= '0;
      in_avail_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_port_q   <= in_port_d;
      in_avail_q  <= in_avail_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.dev_ready = dev_ready;
  assign bus.in_port   = in_port_q;
  assign bus.in_avail  = in_avail_q;
  assign bus.level     = level_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_in_port_fifo.sv
// Bench for in_port_fifo: directed vector table, pointer-wrap sequence, and a
// randomized soak against a queue-based reference model.
module tb_in_port_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  in_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  in_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        vld;
    logic [15:0] data;
    logic        ack;
    logic        clr;
    logic [15:0] e_port;
    int          e_lvl;
    logic        e_uf;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t v(logic r, logic vld, logic [15:0] data, logic ack, logic clr,
                             logic [15:0] e_port, int e_lvl, logic e_uf);
    vec_t t;
    t.r = r; t.vld = vld; t.data = data; t.ack = ack; t.clr = clr;
    t.e_port = e_port; t.e_lvl = e_lvl; t.e_uf = e_uf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic vld, input logic [15:0] data,
                       input logic ack, input logic clr);
    rst           = r;
    bus.dev_valid = vld;
    bus.dev_data  = data;
    bus.cpu_ack   = ack;
    bus.uf_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] port, input int lvl, input logic uf);
    chk({tag, ".in_port"},   32'(bus.in_port),   32'(port));
    chk({tag, ".level"},     32'(bus.level),     32'(lvl));
    chk({tag, ".in_avail"},  32'(bus.in_avail),  32'(lvl != 0));
    chk({tag, ".dev_ready"}, 32'(bus.dev_ready), 32'(lvl != DEPTH));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(uf));
  endtask

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_last;
  logic        m_uf;

  initial begin
    rst           = 1'b1;
    bus.dev_valid = 1'b0;
    bus.dev_data  = '0;
    bus.cpu_ack   = 1'b0;
    bus.uf_clr    = 1'b0;

    //               r  vld data      ack clr  port      lvl uf
    tbl.push_back(v(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0)); // reset
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(v(0, 1, 16'h1234, 0, 0, 16'h1234, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h1234, 0, 0));
    tbl.push_back(v(0, 1, 16'hA000, 0, 0, 16'hA000, 1, 0)); // fill
    tbl.push_back(v(0, 1, 16'hA001, 0, 0, 16'hA000, 2, 0));
    tbl.push_back(v(0, 1, 16'hA002, 0, 0, 16'hA000, 3, 0));
    tbl.push_back(v(0, 1, 16'hA003, 0, 0, 16'hA000, 4, 0));
    tbl.push_back(v(0, 1, 16'hA004, 0, 0, 16'hA000, 4, 0)); // refused when full
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'hA001, 3, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'hA002, 2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'hA003, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'hA003, 0, 0));
    tbl.push_back(v(0, 1, 16'h0011, 0, 0, 16'h0011, 1, 0)); // simultaneous
    tbl.push_back(v(0, 1, 16'h0022, 0, 0, 16'h0011, 2, 0));
    tbl.push_back(v(0, 1, 16'h0033, 1, 0, 16'h0022, 2, 0));
    tbl.push_back(v(0, 1, 16'h0044, 0, 0, 16'h0022, 3, 0));
    tbl.push_back(v(0, 1, 16'h0055, 0, 0, 16'h0022, 4, 0));
    tbl.push_back(v(0, 1, 16'h0066, 1, 0, 16'h0033, 3, 0)); // full: pop only
    tbl.push_back(v(0, 1, 16'h0066, 0, 0, 16'h0033, 4, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0044, 3, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0055, 2, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0066, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0066, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h0066, 0, 1)); // empty ack
    tbl.push_back(v(0, 0, 16'h0000, 0, 1, 16'h0066, 0, 0));
    tbl.push_back(v(0, 1, 16'h5555, 1, 0, 16'h5555, 1, 1)); // ack+push at empty
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h5555, 0, 1));
    tbl.push_back(v(0, 0, 16'h0000, 1, 1, 16'h5555, 0, 1)); // set beats clear
    tbl.push_back(v(0, 0, 16'h0000, 0, 1, 16'h5555, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'h5555, 0, 1));
    tbl.push_back(v(0, 1, 16'h0101, 0, 0, 16'h0101, 1, 1));
    tbl.push_back(v(0, 1, 16'h0202, 0, 0, 16'h0101, 2, 1));
    tbl.push_back(v(0, 1, 16'h0303, 0, 0, 16'h0101, 3, 1));
    tbl.push_back(v(1, 1, 16'h0404, 1, 0, 16'h0000, 0, 0)); // reset mid-op
    tbl.push_back(v(0, 1, 16'hBEEF, 0, 0, 16'hBEEF, 1, 0));
    tbl.push_back(v(0, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0));
    tbl.push_back(v(0, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].vld, tbl[i].data, tbl[i].ack, tbl[i].clr);
      chk_state($sformatf("vec%0d", i), tbl[i].e_port, tbl[i].e_lvl, tbl[i].e_uf);
    end

    // Two more fill/drain rounds to carry both pointers across the wrap point.
    for (int r = 0; r < 2; r++) begin
      logic [15:0] base;
      base = 16'hA000 + 16'(16 * (r + 1));
      for (int k = 0; k < DEPTH; k++) begin
        apply(1'b0, 1'b1, base + 16'(k), 1'b0, 1'b0);
        chk_state($sformatf("wrap%0d_push%0d", r, k), base, k + 1, 1'b0);
      end
      for (int k = 0; k < DEPTH; k++) begin
        apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk_state($sformatf("wrap%0d_pop%0d", r, k),
                  (k < DEPTH - 1) ? base + 16'(k + 1) : base + 16'(DEPTH - 1),
                  DEPTH - 1 - k, 1'b0);
      end
    end

    // Random soak: model starts from a fresh reset.
    apply(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    mq.delete();
    m_last = '0;
    m_uf   = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic        r, vld, ack, clr, was_empty, take;
      logic [15:0] d;
      r   = ($urandom_range(0, 499) == 0);
      vld = ($urandom_range(0, 2) != 0);
      ack = (i < 5000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ((i / 1000) % 2 == 1) ack = ($urandom_range(0, 1) == 0);
      clr = ($urandom_range(0, 15) == 0);
      d   = 16'($urandom);

      if (!r && ack && mq.size() != 0) begin
        chk("soak.consumed", 32'(bus.in_port), 32'(mq[0]));
      end

      if (r) begin
        mq.delete();
        m_last = '0;
        m_uf   = 1'b0;
      end else begin
        was_empty = (mq.size() == 0);
        take      = vld && (mq.size() != DEPTH);
        if (ack && was_empty) m_uf = 1'b1;
        else if (clr)         m_uf = 1'b0;
        if (ack && !was_empty) void'(mq.pop_front());
        if (take) mq.push_back(d);
        if (mq.size() != 0) m_last = mq[0];
      end

      apply(r, vld, d, ack, clr);
      chk_state("soak", m_last, mq.size(), m_uf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
